// File: rtl/rom_player_pkg.sv
// Shared constants for the ROM playback sequencer: modes, FSM states, legal read latency.
// No logic, no latency, no flow control.
package rom_player_pkg;

  localparam logic [1:0] MODE_LOOP     = 2'd0;
  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic int clamp_rd_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/rom_player_vpipe.sv
// Valid shift register tracking reads in flight; last stage is DEPTH cycles after push.
// No backpressure: every push emerges exactly DEPTH cycles later.
module rom_player_vpipe
  import rom_player_pkg::*;
#(
  parameter int DEPTH = RD_LAT_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic last,
  output logic empty
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign last  = sr[DEPTH-1];
  assign empty = (sr == '0);

endmodule

// File: rtl/rom_player.sv
// ROM playback sequencer (loop/one-shot; ping-pong only with ROM_PINGPONG_EN), odata/ovalid RD_LAT cycles after rom_addr.
// No backpressure: consumers take every ovalid beat; stop halts issue and drains in-flight reads before done.
module rom_player
  import rom_player_pkg::*;
#(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int CW     = 2,
  parameter int DIVW   = 8,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [1:0]      mode,
  input  logic [AW-1:0]   addr_lo,
  input  logic [AW-1:0]   addr_hi,
  input  logic [AW-1:0]   step,
  input  logic [DIVW-1:0] div,
  output logic [AW-1:0]   rom_addr,
  input  logic [DW-1:0]   rom_q,
  output logic [DW-1:0]   odata,
  output logic            ovalid,
  output logic [CW-1:0]   cnt,
  output logic            busy,
  output logic            done
);

  localparam int LAT = clamp_rd_lat(RD_LAT);

  state_t          state;
  logic            launch;
  logic [1:0]      mode_r;
  logic [AW-1:0]   lo_r;
  logic [AW-1:0]   hi_r;
  logic [AW-1:0]   step_r;
  logic [DIVW-1:0] div_r;
  logic [DIVW-1:0] dcnt;

  logic [AW:0]     sum;
  logic [AW-1:0]   nxt_addr;
  logic            tick;
  logic            os_end;
  logic            issue;
  logic            pipe_last;
  logic            pipe_empty;

`ifdef ROM_PINGPONG_EN
  logic            dir_dn;
  logic            nxt_dn;
  logic            diff_ok;
`endif

  // One extra bit on the sum so crossing 2^AW is seen as overshooting addr_hi.
  always_comb begin
    sum      = {1'b0, rom_addr} + {1'b0, step_r};
    tick     = (state == ST_RUN) && (dcnt == div_r);
    os_end   = 1'b0;
    nxt_addr = rom_addr;
`ifdef ROM_PINGPONG_EN
    diff_ok  = (rom_addr >= step_r) && ((rom_addr - step_r) >= lo_r);
    nxt_dn   = dir_dn;
    if (dir_dn) begin
      if (diff_ok) begin
        nxt_addr = rom_addr - step_r;
      end else begin
        nxt_dn   = 1'b0;
        nxt_addr = (sum <= {1'b0, hi_r}) ? sum[AW-1:0] : hi_r;
      end
    end else
`endif
    if (sum <= {1'b0, hi_r}) begin
      nxt_addr = sum[AW-1:0];
    end else if (mode_r == MODE_ONESHOT) begin
      os_end = 1'b1;
    end
`ifdef ROM_PINGPONG_EN
    else if (mode_r == MODE_PINGPONG) begin
      nxt_dn   = 1'b1;
      nxt_addr = diff_ok ? (rom_addr - step_r) : lo_r;
    end
`endif
    else begin
      nxt_addr = lo_r;
    end
  end

  assign issue = launch | (tick & ~os_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      launch   <= 1'b0;
      mode_r   <= MODE_LOOP;
      lo_r     <= '0;
      hi_r     <= '0;
      step_r   <= '0;
      div_r    <= '0;
      dcnt     <= '0;
      rom_addr <= '0;
      odata    <= '0;
      ovalid   <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef ROM_PINGPONG_EN
      dir_dn   <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      ovalid <= pipe_last;
      if (pipe_last) odata <= rom_q;

      case (state)
        ST_IDLE: begin
          if (launch) begin
            launch   <= 1'b0;
            state    <= ST_RUN;
            busy     <= 1'b1;
            rom_addr <= lo_r;
            cnt      <= CW'(1);
            dcnt     <= '0;
`ifdef ROM_PINGPONG_EN
            dir_dn   <= 1'b0;
`endif
          end else if (start && !stop && (addr_lo <= addr_hi)) begin
            launch <= 1'b1;
            mode_r <= mode;
            lo_r   <= addr_lo;
            hi_r   <= addr_hi;
            step_r <= (step == '0) ? AW'(1) : step;
            div_r  <= div;
          end
        end

        ST_RUN: begin
          if (tick) begin
            dcnt <= '0;
            if (!os_end) begin
              rom_addr <= nxt_addr;
              cnt      <= cnt + 1'b1;
`ifdef ROM_PINGPONG_EN
              dir_dn   <= nxt_dn;
`endif
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
          if (stop || (tick && os_end)) state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (pipe_empty) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  rom_player_vpipe #(
    .DEPTH(LAT)
  ) u_vpipe (
    .clk  (clk),
    .rst  (rst),
    .push (issue),
    .last (pipe_last),
    .empty(pipe_empty)
  );

endmodule

// File: tb/tb_rom_player.sv
// Directed bench: RD_LAT=1 instance with identity ROM, RD_LAT=3 instance with a 2-flop ROM model.
module tb_rom_player;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] mode;
  logic [7:0] addr_lo, addr_hi, step, div;

  logic [7:0] rom_addr1, rom_q1, odata1;
  logic [7:0] rom_addr3, rom_q3, odata3, d1, d2;
  logic       ovalid1, ovalid3, busy1, busy3, done1, done3;
  logic [1:0] cnt1, cnt3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_q1 = rom_addr1;
  always @(posedge clk) begin
    d1 <= rom_addr3;
    d2 <= d1;
  end
  assign rom_q3 = d2;

  rom_player #(.AW(8), .DW(8), .CW(2), .DIVW(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .addr_lo(addr_lo), .addr_hi(addr_hi), .step(step), .div(div),
    .rom_addr(rom_addr1), .rom_q(rom_q1), .odata(odata1), .ovalid(ovalid1),
    .cnt(cnt1), .busy(busy1), .done(done1)
  );

  rom_player #(.AW(8), .DW(8), .CW(2), .DIVW(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .addr_lo(addr_lo), .addr_hi(addr_hi), .step(step), .div(div),
    .rom_addr(rom_addr3), .rom_q(rom_q3), .odata(odata3), .ovalid(ovalid3),
    .cnt(cnt3), .busy(busy3), .done(done3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Config is scrambled right after the latching edge; the DUT must ignore it.
  task automatic begin_run(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [7:0] st, input logic [7:0] dv);
    mode = m; addr_lo = lo; addr_hi = hi; step = st; div = dv;
    start = 1'b1;
    cyc();
    start = 1'b0;
    mode = 2'd1; addr_lo = 8'hff; addr_hi = 8'h00; step = 8'd99; div = 8'd7;
    cyc();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy1 || busy3) && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (busy1 || busy3) begin
      errors++;
      $display("FAIL wait_idle: busy1=%0b busy3=%0b, required both 0 within 40 cycles", busy1, busy3);
    end
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
    addr_lo = 8'd0; addr_hi = 8'd0; step = 8'd0; div = 8'd0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if ({rom_addr1, odata1, ovalid1, cnt1, busy1, done1} !== 21'd0) begin
      errors++;
      $display("FAIL reset1: outputs=%h required 0", {rom_addr1, odata1, ovalid1, cnt1, busy1, done1});
    end
    checks++;
    if ({rom_addr3, odata3, ovalid3, cnt3, busy3, done3} !== 21'd0) begin
      errors++;
      $display("FAIL reset3: outputs=%h required 0", {rom_addr3, odata3, ovalid3, cnt3, busy3, done3});
    end
  endtask

  task automatic test_loop();
    int dn = 0;
    begin_run(2'd0, 8'd0, 8'd3, 8'd1, 8'd0);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL loop_busy: busy=%0b required 1", busy1);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rom_addr1 !== 8'(k % 4)) begin
        errors++;
        $display("FAIL loop_addr[%0d]: got %0d required %0d", k, rom_addr1, k % 4);
      end
      checks++;
      if (cnt1 !== 2'((k + 1) % 4)) begin
        errors++;
        $display("FAIL loop_cnt[%0d]: got %0d required %0d", k, cnt1, (k + 1) % 4);
      end
      if (k > 0) begin
        checks++;
        if (ovalid1 !== 1'b1 || odata1 !== 8'((k - 1) % 4)) begin
          errors++;
          $display("FAIL loop_data[%0d]: ovalid=%0b odata=%0d required 1/%0d", k, ovalid1, odata1, (k - 1) % 4);
        end
      end
      start = (k == 4);
      cyc();
    end
    start = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (done1) dn++;
      cyc();
    end
    checks++;
    if (dn != 1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: done pulses=%0d busy=%0b required 1/0", dn, busy1);
    end
    wait_idle();
  endtask

  task automatic test_oneshot();
    int ea[6] = '{10, 14, 18, 18, 18, 18};
    int ev[6] = '{0, 1, 1, 1, 0, 0};
    int ed[6] = '{0, 10, 14, 18, 0, 0};
    int eb[6] = '{1, 1, 1, 1, 0, 0};
    int ef[6] = '{0, 0, 0, 0, 1, 0};
    begin_run(2'd1, 8'd10, 8'd20, 8'd4, 8'd0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rom_addr1 !== 8'(ea[i])) begin
        errors++;
        $display("FAIL oneshot_addr[%0d]: got %0d required %0d", i, rom_addr1, ea[i]);
      end
      checks++;
      if (ovalid1 !== 1'(ev[i])) begin
        errors++;
        $display("FAIL oneshot_ovalid[%0d]: got %0b required %0d", i, ovalid1, ev[i]);
      end
      if (ev[i] == 1) begin
        checks++;
        if (odata1 !== 8'(ed[i])) begin
          errors++;
          $display("FAIL oneshot_odata[%0d]: got %0d required %0d", i, odata1, ed[i]);
        end
      end
      checks++;
      if (busy1 !== 1'(eb[i]) || done1 !== 1'(ef[i])) begin
        errors++;
        $display("FAIL oneshot_busy_done[%0d]: got %0b/%0b required %0d/%0d", i, busy1, done1, eb[i], ef[i]);
      end
      cyc();
    end
    wait_idle();
  endtask

  task automatic test_ignored_start();
    mode = 2'd0; addr_lo = 8'd9; addr_hi = 8'd3; step = 8'd1; div = 8'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    checks++;
    if (busy1 !== 1'b0 || rom_addr1 !== 8'd18) begin
      errors++;
      $display("FAIL ignore_lo_gt_hi: busy=%0b addr=%0d required 0/18", busy1, rom_addr1);
    end
    addr_lo = 8'd0; addr_hi = 8'd3;
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    repeat (4) cyc();
    checks++;
    if (busy1 !== 1'b0 || rom_addr1 !== 8'd18) begin
      errors++;
      $display("FAIL ignore_start_with_stop: busy=%0b addr=%0d required 0/18", busy1, rom_addr1);
    end
  endtask

  task automatic test_pingpong();
`ifdef ROM_PINGPONG_EN
    int ea[8] = '{0, 2, 4, 2, 0, 2, 4, 2};
`else
    int ea[8] = '{0, 2, 4, 0, 2, 4, 0, 2};
`endif
    begin_run(2'd2, 8'd0, 8'd5, 8'd2, 8'd0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rom_addr1 !== 8'(ea[i])) begin
        errors++;
        $display("FAIL pingpong_addr[%0d]: got %0d required %0d", i, rom_addr1, ea[i]);
      end
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    wait_idle();
  endtask

  task automatic test_divider();
    begin_run(2'd0, 8'd0, 8'd7, 8'd1, 8'd2);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (rom_addr1 !== 8'(k / 3) || ovalid1 !== (k % 3 == 1)) begin
        errors++;
        $display("FAIL divider[%0d]: addr=%0d ovalid=%0b required %0d/%0b", k, rom_addr1, ovalid1, k / 3, k % 3 == 1);
      end
      if (k % 3 == 1) begin
        checks++;
        if (odata1 !== 8'(k / 3)) begin
          errors++;
          $display("FAIL divider_odata[%0d]: got %0d required %0d", k, odata1, k / 3);
        end
      end
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    wait_idle();
  endtask

  task automatic test_boundary();
    begin_run(2'd0, 8'd16, 8'd255, 8'd16, 8'd0);
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (rom_addr1 !== 8'(16 * ((k % 15) + 1))) begin
        errors++;
        $display("FAIL boundary_addr[%0d]: got %0d required %0d", k, rom_addr1, 16 * ((k % 15) + 1));
      end
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    wait_idle();
  endtask

  task automatic test_stop_lat3();
    int nov = 0, last = -1, ovlast = -1, done_at = -1;
    logic b5 = 1'b0, b6 = 1'b1;
    begin_run(2'd0, 8'd0, 8'd7, 8'd1, 8'd1);
    for (int k = 0; k < 11; k++) begin
      if (ovalid3) begin
        nov++;
        last = int'(odata3);
        ovlast = k;
      end
      if (done3 && done_at < 0) done_at = k;
      if (k == 5) b5 = busy3;
      if (k == 6) b6 = busy3;
      stop = (k == 2);
      cyc();
    end
    stop = 1'b0;
    checks++;
    if (nov != 2 || last != 1 || ovlast != 5) begin
      errors++;
      $display("FAIL stop_lat3_valids: count=%0d last=%0d at=%0d required 2/1/5", nov, last, ovlast);
    end
    checks++;
    if (done_at != 6 || b5 !== 1'b1 || b6 !== 1'b0) begin
      errors++;
      $display("FAIL stop_lat3_done: done_at=%0d busy5=%0b busy6=%0b required 6/1/0", done_at, b5, b6);
    end
    wait_idle();
  endtask

  task automatic test_reset_midrun();
    int seen = 0;
    begin_run(2'd0, 8'd0, 8'd7, 8'd1, 8'd0);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if ({rom_addr1, odata1, ovalid1, cnt1, busy1, done1} !== 21'd0) begin
      errors++;
      $display("FAIL midrun_reset1: outputs=%h required 0", {rom_addr1, odata1, ovalid1, cnt1, busy1, done1});
    end
    checks++;
    if ({rom_addr3, odata3, ovalid3, cnt3, busy3, done3} !== 21'd0) begin
      errors++;
      $display("FAIL midrun_reset3: outputs=%h required 0", {rom_addr3, odata3, ovalid3, cnt3, busy3, done3});
    end
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (done1 || done3 || ovalid1 || ovalid3 || busy1 || busy3) seen++;
      cyc();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrun_quiet: active cycles=%0d required 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_loop();
    test_oneshot();
    test_ignored_start();
    test_pingpong();
    test_divider();
    test_boundary();
    test_stop_lat3();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
